// File: rtl/matrix_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
package matrix_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_t;

  // A BCD digit at or above this value gets +3 before the shift
  localparam logic [3:0] BCD_ADJ_TH = 4'd5;

  // Display word width: {ovf, tens[3:0], ones[3:0]}
  localparam int DISP_W = 9;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready request channel into the converter, plus its result/done outputs.
interface bin2bcd_seq_if
  import matrix_pkg::*;
#(
  parameter int IN_W = 8
) ();

  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic              done;
  logic [DISP_W-1:0] result;

  // Upstream producer / display consumer side
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  done,
    input  result
  );

  // Converter side
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output done,
    output result
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step: if the digit is 5 or more, add 3 (4-bit wrap, no carry out).
module bcd_digit_adj
  import matrix_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Correction applied before each left shift so the digit carries correctly into the next one
  assign dout = (din >= BCD_ADJ_TH) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary to BCD converter.
// The display word {ovf, tens, ones} only changes together with the one-cycle done pulse,
// so the decoder downstream never sees partial conversion values.
module bin2bcd_seq
  import matrix_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int              CNT_W    = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
  localparam int              CAT_W    = 12 + IN_W;

  b2b_state_t        state_reg, state_next;
  logic [IN_W-1:0]   bin_reg, bin_next;
  logic [11:0]       bcd_reg, bcd_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DISP_W-1:0] result_reg, result_next;
  logic              done_reg, done_next;
  logic              in_ready_reg, in_ready_next;

  logic [11:0]       bcd_adj;
  logic [CAT_W-1:0]  cat_shift;
  logic [11:0]       bcd_shift;
  logic [IN_W-1:0]   bin_shift;

  // Three digit correctors (ones, tens, hundreds) working on the current accumulator
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (bcd_reg[gi*4 +: 4]),
        .dout (bcd_adj[gi*4 +: 4])
      );
    end
  endgenerate

  // Corrected accumulator and binary shift register move left together by one bit
  assign cat_shift = {bcd_adj, bin_reg} << 1;
  assign bcd_shift = cat_shift[CAT_W-1:IN_W];
  assign bin_shift = cat_shift[IN_W-1:0];

  // Next-state, datapath update and registered output values
  always_comb begin
    state_next    = state_reg;
    bin_next      = bin_reg;
    bcd_next      = bcd_reg;
    cnt_next      = cnt_reg;
    result_next   = result_reg;
    done_next     = 1'b0;
    in_ready_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid && in_ready_reg) begin
          bin_next   = bus.in_data;
          bcd_next   = 12'h000;
          cnt_next   = '0;
          state_next = SHIFT;
        end else begin
          in_ready_next = 1'b1;
        end
      end
      SHIFT: begin
        bcd_next = bcd_shift;
        bin_next = bin_shift;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          // Final shift: publish the word so it and done appear together in DONE
          state_next  = DONE;
          done_next   = 1'b1;
          result_next = {(bcd_shift[11:8] != 4'd0), bcd_shift[7:0]};
        end
      end
      DONE: begin
        state_next    = IDLE;
        in_ready_next = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and register update; reset abandons any conversion and blanks the display to "00"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      bcd_reg      <= 12'h000;
      cnt_reg      <= '0;
      result_reg   <= '0;
      done_reg     <= 1'b0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bin_reg      <= bin_next;
      bcd_reg      <= bcd_next;
      cnt_reg      <= cnt_next;
      result_reg   <= result_next;
      done_reg     <= done_next;
      in_ready_reg <= in_ready_next;
    end
  end

  assign bus.in_ready = in_ready_reg;
  assign bus.done     = done_reg;
  assign bus.result   = result_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: reset state, conversions, busy-ignore, reset abort, 0..255 sweep.
module tb_bin2bcd_seq;
  import matrix_pkg::*;

  localparam int IN_W = 8;

  logic clk = 1'b0;
  logic rst;

  int checks_total  = 0;
  int checks_passed = 0;

  bin2bcd_seq_if #(.IN_W(IN_W)) bus ();

  bin2bcd_seq #(.IN_W(IN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks_total++;
    if (obs == exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Present v, wait for acceptance, then wait for done and check the published word
  task automatic convert(input int v, input logic [8:0] exp, input string tag);
    int n;
    logic held;
    logic [8:0] prev;
    @(negedge clk);
    bus.in_data  = IN_W'(v);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, int'(bus.in_ready), 1);
    prev = bus.result;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, int'(bus.in_ready), 0);
    n = 0;
    held = 1'b1;
    while (n < 50) begin
      if (bus.result !== prev) held = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (bus.done) break;
    end
    check({tag, "_hold"}, int'(held), 1);
    check({tag, "_lat"}, n, IN_W);
    check({tag, "_res"}, int'(bus.result), int'(exp));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, int'(bus.done), 0);
    check({tag, "_rdy_after"}, int'(bus.in_ready), 1);
    $display("conv %0d -> result %03h (expected %03h) latency %0d", v, bus.result, exp, n);
  endtask

  initial begin
    int n;
    logic ignored;
    logic [8:0] exp;

    // 1. Reset state
    rst          = 1'b1;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", int'(bus.result), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", int'(bus.in_ready), 1);
    check("post_rst_done", int'(bus.done), 0);
    convert(0, 9'h000, "zero");

    // 2/3. Directed values including the overflow boundary
    convert(42,  9'h042, "v42");
    convert(99,  9'h099, "v99");
    convert(100, 9'h100, "v100");
    convert(255, 9'h155, "v255");

    // 4. Busy: 80 held on the bus during SHIFT/DONE is ignored until in_ready
    @(negedge clk);
    bus.in_data  = 8'd37;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_data = 8'd80;
    n = 0;
    ignored = 1'b1;
    while (n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) break;
      if (bus.in_ready) ignored = 1'b0;
    end
    check("busy_ignored", int'(ignored), 1);
    check("busy37_lat", n, IN_W);
    check("busy37_res", int'(bus.result), 9'h037);
    @(posedge clk);
    #1;
    check("busy_idle_ready", int'(bus.in_ready), 1);
    check("busy_idle_res", int'(bus.result), 9'h037);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("busy80_accept", int'(bus.in_ready), 0);
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) break;
    end
    check("busy80_lat", n, IN_W);
    check("busy80_res", int'(bus.result), 9'h080);
    $display("conv 37 then 80 -> result %03h (expected 080)", bus.result);

    // 5. Reset in the middle of converting 63
    @(negedge clk);
    bus.in_data  = 8'd63;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_res", int'(bus.result), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_ready", int'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    $display("abort 63 -> result %03h (expected 000)", bus.result);
    convert(63, 9'h063, "v63_after_rst");

    // 6. Sweep every 8-bit value
    for (int v = 0; v < 256; v++) begin
      exp = {(v >= 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert(v, exp, $sformatf("sweep%0d", v));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
